// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM states, decode regions, open-bus value.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_IO       = 2'd1,
    REG_UNMAPPED = 2'd2
  } region_e;

  // Value driven on DI when nothing answers the CPU.
  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/bus_resp_if.sv
// CPU-side bus cycle: address, write strobe/data, read data and ready.
interface bus_resp_if;
  logic [15:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic [7:0]  DI;
  logic        RDY;

  modport master (output AB, output WE, output DO, input DI, input RDY);
  modport slave  (input AB, input WE, input DO, output DI, output RDY);
endinterface

// File: rtl/bus_decode.sv
// Combinational CPU address decode into RAM / I/O page / unmapped.
module bus_decode
  import bus_pkg::*;
#(
  parameter logic [7:0] IO_PAGE = 8'hD0
) (
  input  logic [15:0] i_ab,
  output region_e     o_region
);

  logic [7:0] w_unused_ab_lo;
  assign w_unused_ab_lo = i_ab[7:0];

  // RAM takes priority so a low IO_PAGE cannot shadow RAM.
  always_comb begin
    o_region = REG_UNMAPPED;
    if (!i_ab[15])               o_region = REG_RAM;
    else if (i_ab[15:8] == IO_PAGE) o_region = REG_IO;
  end

endmodule

// File: rtl/bus_resp.sv
// Memory-side bus responder: zero-wait RAM, req/ack I/O, open-bus elsewhere.
// Optional feature macro: BUS_TIMEOUT_EN (aborts stalled I/O accesses).
module bus_resp
  import bus_pkg::*;
#(
  parameter logic [7:0]  IO_PAGE     = 8'hD0,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_resp_if.slave     cpu,
  output logic [14:0]   ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          io_req,
  output logic          io_we,
  output logic [7:0]    io_addr,
  output logic [7:0]    io_wdata,
  input  logic          io_ack,
  input  logic [7:0]    io_rdata,
  output logic          err,
  input  logic          err_clr
);

  region_e    w_region;
  logic       w_io_hit;
  logic       w_timeout;
  logic [7:0] w_di;
  state_e     r_state;
  logic       r_io_req;
  logic       r_io_we;
  logic [7:0] r_io_addr;
  logic [7:0] r_io_wdata;
  logic [7:0] r_rdata_q;

  bus_decode #(.IO_PAGE(IO_PAGE)) u_decode (
    .i_ab     (cpu.AB),
    .o_region (w_region)
  );

  assign w_io_hit = (w_region == REG_IO);

`ifdef BUS_TIMEOUT_EN
  logic [4:0] r_cnt;
  logic       r_err;

  assign w_timeout = (r_state == ST_REQ) && !io_ack &&
                     (r_cnt == 5'(TIMEOUT_CYC - 1));

  // Count REQ cycles without ack; cleared on REQ entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_cnt <= '0;
    else if (r_state == ST_IDLE && w_io_hit)  r_cnt <= '0;
    else if (r_state == ST_REQ && !io_ack && !w_timeout) r_cnt <= r_cnt + 5'd1;
  end

  // Sticky timeout flag; a coincident set overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

  assign err = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  // I/O access sequencer: latch request, wait for ack (or timeout), complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_io_req   <= 1'b0;
      r_io_we    <= 1'b0;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
      r_rdata_q  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_io_hit) begin
            r_io_addr  <= cpu.AB[7:0];
            r_io_wdata <= cpu.DO;
            r_io_we    <= cpu.WE;
            r_io_req   <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (io_ack) begin
            r_rdata_q <= io_rdata;
            r_io_req  <= 1'b0;
            r_state   <= ST_DONE;
          end else if (w_timeout) begin
            r_rdata_q <= OPEN_BUS;
            r_io_req  <= 1'b0;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read data mux: completed I/O, RAM, or open bus.
  always_comb begin
    w_di = OPEN_BUS;
    if (r_state == ST_DONE)       w_di = r_io_we ? OPEN_BUS : r_rdata_q;
    else if (w_region == REG_RAM) w_di = ram_rdata;
  end

  assign cpu.DI    = w_di;
  assign cpu.RDY   = ((r_state == ST_IDLE) && !w_io_hit) || (r_state == ST_DONE);
  assign ram_addr  = cpu.AB[14:0];
  assign ram_wdata = cpu.DO;
  assign ram_we    = cpu.WE && (w_region == REG_RAM) && (r_state == ST_IDLE);
  assign io_req    = r_io_req;
  assign io_we     = r_io_we;
  assign io_addr   = r_io_addr;
  assign io_wdata  = r_io_wdata;

endmodule

// File: tb/tb_bus_resp.sv
// Directed self-checking bench for bus_resp.
module tb_bus_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        io_req;
  logic        io_we;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_ack;
  logic [7:0]  io_rdata;
  logic        err;
  logic        err_clr;
  int          checks   = 0;
  int          failures = 0;
  int          lowc;

  logic [7:0] mem [0:32767];

  bus_resp_if bus ();

  bus_resp #(.IO_PAGE(8'hD0), .TIMEOUT_CYC(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_ack    (io_ack),
    .io_rdata  (io_rdata),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  // External SRAM: async read, write on posedge.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.AB = 16'h0123; bus.WE = 1'b0; bus.DO = 8'h00;
    io_ack = 1'b0; io_rdata = 8'h00; err_clr = 1'b0;
    #2;
    chk("rst_io_req", io_req, 1'b0);
    chk("rst_io_we", io_we, 1'b0);
    chk("rst_io_addr", io_addr, 8'h00);
    chk("rst_io_wdata", io_wdata, 8'h00);
    chk("rst_err", err, 1'b0);
    chk("rst_rdy", bus.RDY, 1'b1);
    chk("rst_ram_we", ram_we, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // RAM write then read
    bus.AB = 16'h0123; bus.WE = 1'b1; bus.DO = 8'h5A; #1;
    chk("ramw_we", ram_we, 1'b1);
    chk("ramw_rdy", bus.RDY, 1'b1);
    chk("ramw_addr", ram_addr, 15'h0123);
    chk("ramw_wdata", ram_wdata, 8'h5A);
    tick();
    bus.WE = 1'b0; #1;
    chk("ramr_we", ram_we, 1'b0);
    chk("ramr_di", bus.DI, 8'h5A);
    chk("ramr_rdy", bus.RDY, 1'b1);
    tick();

    // Unmapped read and write
    bus.AB = 16'hC000; #1;
    chk("unm_di", bus.DI, 8'hFF);
    chk("unm_rdy", bus.RDY, 1'b1);
    bus.WE = 1'b1; #1;
    chk("unm_ram_we", ram_we, 1'b0);
    tick();
    bus.WE = 1'b0;

    // I/O read, ack in third REQ cycle
    lowc = 0;
    bus.AB = 16'hD010; #1;
    chk("ior_det_rdy", bus.RDY, 1'b0);
    chk("ior_det_req", io_req, 1'b0);
    if (bus.RDY == 1'b0) lowc++;
    tick();
    chk("ior_req1", io_req, 1'b1);
    chk("ior_addr", io_addr, 8'h10);
    chk("ior_we", io_we, 1'b0);
    if (bus.RDY == 1'b0) lowc++;
    tick();
    if (bus.RDY == 1'b0) lowc++;
    tick();
    io_ack = 1'b1; io_rdata = 8'h3C; #1;
    chk("ior_req3_rdy", bus.RDY, 1'b0);
    if (bus.RDY == 1'b0) lowc++;
    tick();
    io_ack = 1'b0; io_rdata = 8'h00;
    chk("ior_done_rdy", bus.RDY, 1'b1);
    chk("ior_done_di", bus.DI, 8'h3C);
    chk("ior_done_req", io_req, 1'b0);
    chk("ior_lowc", lowc, 4);
    tick();
    bus.AB = 16'h0123; #1;
    chk("ior_idle_rdy", bus.RDY, 1'b1);

    // I/O write, immediate ack
    bus.AB = 16'hD020; bus.WE = 1'b1; bus.DO = 8'hA5; #1;
    chk("iow_ram_we", ram_we, 1'b0);
    chk("iow_det_rdy", bus.RDY, 1'b0);
    tick();
    io_ack = 1'b1; #1;
    chk("iow_we", io_we, 1'b1);
    chk("iow_wdata", io_wdata, 8'hA5);
    chk("iow_addr", io_addr, 8'h20);
    chk("iow_req", io_req, 1'b1);
    tick();
    io_ack = 1'b0;
    chk("iow_done_rdy", bus.RDY, 1'b1);
    chk("iow_done_di", bus.DI, 8'hFF);
    tick();
    bus.AB = 16'h0123; bus.WE = 1'b0;

    // Ack in IDLE is ignored
    io_ack = 1'b1;
    tick();
    io_ack = 1'b0;
    chk("idle_ack_req", io_req, 1'b0);
    chk("idle_ack_rdy", bus.RDY, 1'b1);

`ifdef BUS_TIMEOUT_EN
    // Timeout after 16 REQ cycles; coincident clear loses to set
    bus.AB = 16'hD030;
    tick();
    for (int unsigned i = 0; i < 15; i++) tick();
    chk("to_req16", io_req, 1'b1);
    chk("to_req16_err", err, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_done_req", io_req, 1'b0);
    chk("to_done_di", bus.DI, 8'hFF);
    chk("to_done_err", err, 1'b1);
    chk("to_done_rdy", bus.RDY, 1'b1);
    tick();
    bus.AB = 16'h0123;
    tick();
    chk("to_err_sticky", err, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", err, 1'b0);

    // Ack exactly on cycle 16 wins over the timeout
    bus.AB = 16'hD030;
    tick();
    for (int unsigned i = 0; i < 15; i++) tick();
    io_ack = 1'b1; io_rdata = 8'h77;
    tick();
    io_ack = 1'b0;
    chk("to16_di", bus.DI, 8'h77);
    chk("to16_err", err, 1'b0);
    tick();
    bus.AB = 16'h0123;
`else
    // Without timeout REQ waits indefinitely and err stays low
    bus.AB = 16'hD030;
    tick();
    for (int unsigned i = 0; i < 20; i++) tick();
    chk("nto_req", io_req, 1'b1);
    chk("nto_err", err, 1'b0);
    chk("nto_rdy", bus.RDY, 1'b0);
    io_ack = 1'b1; io_rdata = 8'h77;
    tick();
    io_ack = 1'b0;
    chk("nto_di", bus.DI, 8'h77);
    tick();
    bus.AB = 16'h0123;
`endif
    tick();

    // Reset asserted during REQ
    bus.AB = 16'hD040;
    tick();
    chk("rreq_req", io_req, 1'b1);
    #2;
    rst_n = 1'b0; #1;
    chk("rreq_req_drop", io_req, 1'b0);
    chk("rreq_rdy", bus.RDY, 1'b0);
    io_ack = 1'b1; bus.AB = 16'h0123;
    tick();
    rst_n = 1'b1; #1;
    chk("rreq_idle_rdy", bus.RDY, 1'b1);
    tick();
    io_ack = 1'b0;
    chk("rreq_late_ack_req", io_req, 1'b0);
    chk("rreq_late_ack_rdy", bus.RDY, 1'b1);
    chk("rreq_io_we", io_we, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_resp.md
# bus_resp

Memory-side responder for the CPU address/data bus. It decodes each CPU bus cycle, presented as the 16-bit address, the write strobe and the write data, into one of three regions: RAM, I/O page or unmapped. RAM cycles complete without wait states. I/O cycles are forwarded over a req/ack handshake, and `RDY` is held low until that handshake completes. The block sits between the CPU core's address-bus outputs (ABL/ABH) and the board's SRAM and peripheral logic.

## Interface
- `IO_PAGE`, 8'hD0: value of AB[15:8] that selects the I/O region.
- `TIMEOUT_CYC`, 16: number of REQ-state cycles before an I/O access is aborted (only with timeout enabled).
- `clk` input 1: system clock; all state updates on posedge.
- `rst_n` input 1: reset; asynchronous assertion, active-low.
- `AB` input 16: CPU address, stable for the whole bus cycle.
- `WE` input 1: CPU write strobe (1 = write).
- `DO` input 8: CPU write data.
- `DI` output 8: read data returned to the CPU.
- `RDY` output 1: cycle complete; the CPU holds AB/WE/DO while it is 0.
- `ram_addr` output 15: equals AB[14:0].
- `ram_we` output 1: SRAM write enable.
- `ram_wdata` output 8: equals DO.
- `ram_rdata` input 8: SRAM read data, combinational from `ram_addr`.
- `io_req` output 1: I/O request, registered.
- `io_we` output 1: I/O write, latched.
- `io_addr` output 8: latched AB[7:0].
- `io_wdata` output 8: latched DO.
- `io_ack` input 1: I/O completion, single-cycle pulse.
- `io_rdata` input 8: I/O read data, valid when `io_ack` = 1.
- `err` output 1: sticky I/O timeout flag.
- `err_clr` input 1: synchronous clear of `err`.

## Operation
- Decode is combinational:
  - `ram_hit` when AB[15] = 0.
  - `io_hit` when AB[15:8] = IO_PAGE.
  - Otherwise the cycle is unmapped.
- RAM cycle:
  - RDY = 1 and DI = `ram_rdata`.
  - `ram_we` = WE & ram_hit & (state = IDLE).
- Unmapped cycle: RDY = 1, DI = 8'hFF, writes are discarded.
- I/O state machine:
  - IDLE: if io_hit, then RDY = 0. At the next posedge, latch `io_addr`, `io_wdata` and `io_we`, set `io_req` = 1 and go to REQ.
  - REQ: RDY = 0 and `io_req` held at 1. On a posedge with `io_ack` = 1, latch `io_rdata` into `rdata_q`, clear `io_req` and go to DONE.
  - DONE: RDY = 1. DI = `rdata_q` for reads and 8'hFF for writes. At the next posedge go to IDLE.
- RDY = (IDLE & ~io_hit) | DONE.
- `io_ack` is ignored in IDLE and DONE.
- `err` is set on timeout. `err_clr` clears it; if set and clear coincide, set wins.
- Reset values:
  - State is IDLE.
  - `io_req`, `io_we` and `err` are 0.
  - `io_addr`, `io_wdata` and `rdata_q` are 8'h00.
  - RDY and DI follow the decode of the current AB.

## Timing
- RAM and unmapped cycles take 1 cycle with zero wait states.
- I/O cycles take at least 3 cycles: the detect cycle, REQ with `io_ack` in its first cycle, and DONE.
- Total I/O latency is 2 + (number of REQ cycles).
- `io_req` rises 1 cycle after the CPU presents the I/O address and falls at the posedge that samples `io_ack`.
- Back-to-back I/O cycles: DONE → IDLE → a fresh detect. `io_req` is therefore low for at least 2 cycles between requests.
- Reset asserted mid-access: `io_req` drops immediately and state returns to IDLE. A late `io_ack` after reset is ignored.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - A 5-bit counter clears on REQ entry and increments on each REQ cycle without `io_ack`.
  - When the count reaches TIMEOUT_CYC, drop `io_req`, set `rdata_q` = 8'hFF, set `err` and go to DONE.
  - If `io_ack` arrives in the same cycle as the timeout, the ack wins and `err` is not set.
- Not defined: REQ waits indefinitely. The counter is absent and `err` is tied to 0.

## Structure
- Shared package `bus_pkg`:
  - State enum: IDLE, REQ, DONE.
  - Region enum: RAM, IO, UNMAPPED.
  - Constant 8'hFF for the open-bus value.
- Sub-module `bus_decode`: purely combinational AB → region, reused by other bus masters. The FSM, latches and timeout stay in `bus_resp`.

## Test plan
- RAM write then read: write AB = 16'h0123 with DO = 8'h5A, then read AB = 16'h0123 → `ram_we` pulses for 1 cycle, read returns DI = 8'h5A, RDY stays 1 throughout.
- I/O read: AB = 16'hD010 with `io_ack` after 3 REQ cycles and `io_rdata` = 8'h3C → `io_addr` = 8'h10, RDY low for 4 cycles, DI = 8'h3C in DONE.
- I/O write with immediate ack: WE = 1, DO = 8'hA5 → `io_we` = 1, `io_wdata` = 8'hA5, 3-cycle access.
- Timeout (`BUS_TIMEOUT_EN`, TIMEOUT_CYC = 16): no `io_ack` → `io_req` drops after 16 REQ cycles, DI = 8'hFF, `err` = 1 until `err_clr`. Repeat with `io_ack` exactly on cycle 16 → `err` stays 0.
- Unmapped read of AB = 16'hC000 → DI = 8'hFF and RDY = 1. Also assert `rst_n` = 0 during REQ → `io_req` = 0 immediately, state returns to IDLE.
